// File: rtl/bio_gpio_infilter.sv
// rtl/bio_gpio_infilter.sv - pad input synchronizer, per-pin glitch filter and sticky edge events for BIO gpio_in
// Optional pad/loopback mux per pin is built when BIO_INFILT_LOOPBACK_EN is defined.
`timescale 1ns/1ps

module bio_gpio_infilter #(
    parameter int NPIN = 32,
    parameter int CW   = 4
) (
    input  logic            aclk,
    input  logic            reset,
    input  logic [NPIN-1:0] pad_in,
    input  logic [NPIN-1:0] filt_en,
    input  logic [CW-1:0]   filt_len,
    input  logic [NPIN-1:0] rise_en,
    input  logic [NPIN-1:0] fall_en,
    input  logic [NPIN-1:0] evt_clr,
    input  logic            lb_en,
    input  logic [NPIN-1:0] lb_out,
    input  logic [NPIN-1:0] lb_dir,
    output logic [NPIN-1:0] gpio_in,
    output logic [NPIN-1:0] evt_status,
    output logic            irq
);

    logic [NPIN-1:0] src;
    logic [NPIN-1:0] s1;
    logic [NPIN-1:0] s2;
    logic [CW-1:0]   cnt     [NPIN];
    logic [CW-1:0]   cnt_nxt [NPIN];
    logic [NPIN-1:0] gpio_nxt;
    logic [NPIN-1:0] rise;
    logic [NPIN-1:0] fall;
    logic [NPIN-1:0] evt_nxt;
    logic [CW-1:0]   nm1;
    logic            bypass;

`ifdef BIO_INFILT_LOOPBACK_EN
    assign src = lb_en ? ((lb_dir & lb_out) | (~lb_dir & pad_in)) : pad_in;
`else
    logic unused_lb;
    assign unused_lb = ^{lb_en, lb_out, lb_dir};
    assign src       = pad_in;
`endif

    // A length of 0 or 1 both mean "accept on the first mismatching cycle".
    assign bypass = (filt_len <= CW'(1));
    assign nm1    = (filt_len == '0) ? '0 : filt_len - 1'b1;

    always_comb begin
        gpio_nxt = gpio_in;
        for (int j = 0; j < NPIN; j++) begin
            cnt_nxt[j] = '0;
            if (!filt_en[j] || bypass) begin
                gpio_nxt[j] = s2[j];
            end else if (s2[j] != gpio_in[j]) begin
                // cnt counts mismatching cycles already seen; it stops at N-1 so it cannot wrap
                if (cnt[j] >= nm1) begin
                    gpio_nxt[j] = s2[j];
                end else begin
                    cnt_nxt[j] = cnt[j] + 1'b1;
                end
            end
        end
    end

    assign rise    = gpio_nxt & ~gpio_in;
    assign fall    = ~gpio_nxt & gpio_in;
    assign evt_nxt = (evt_status & ~evt_clr) | (rise & rise_en) | (fall & fall_en);

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            s1         <= '0;
            s2         <= '0;
            gpio_in    <= '0;
            evt_status <= '0;
            for (int j = 0; j < NPIN; j++) begin
                cnt[j] <= '0;
            end
        end else begin
            s1         <= src;
            s2         <= s1;
            gpio_in    <= gpio_nxt;
            evt_status <= evt_nxt;
            for (int j = 0; j < NPIN; j++) begin
                cnt[j] <= cnt_nxt[j];
            end
        end
    end

    assign irq = |evt_status;

endmodule

// File: tb/tb_bio_gpio_infilter.sv
// tb/tb_bio_gpio_infilter.sv - directed self-checking bench for bio_gpio_infilter
`timescale 1ns/1ps

module tb_bio_gpio_infilter;

    localparam int NPIN = 32;
    localparam int CW   = 4;

    logic            aclk;
    logic            reset;
    logic [NPIN-1:0] pad_in;
    logic [NPIN-1:0] filt_en;
    logic [CW-1:0]   filt_len;
    logic [NPIN-1:0] rise_en;
    logic [NPIN-1:0] fall_en;
    logic [NPIN-1:0] evt_clr;
    logic            lb_en;
    logic [NPIN-1:0] lb_out;
    logic [NPIN-1:0] lb_dir;
    logic [NPIN-1:0] gpio_in;
    logic [NPIN-1:0] evt_status;
    logic            irq;

    int n_total;
    int n_pass;

    bio_gpio_infilter #(.NPIN(NPIN), .CW(CW)) dut (
        .aclk       (aclk),
        .reset      (reset),
        .pad_in     (pad_in),
        .filt_en    (filt_en),
        .filt_len   (filt_len),
        .rise_en    (rise_en),
        .fall_en    (fall_en),
        .evt_clr    (evt_clr),
        .lb_en      (lb_en),
        .lb_out     (lb_out),
        .lb_dir     (lb_dir),
        .gpio_in    (gpio_in),
        .evt_status (evt_status),
        .irq        (irq)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    initial begin
        n_total  = 0;
        n_pass   = 0;
        reset    = 1'b1;
        pad_in   = '0;
        filt_en  = '0;
        filt_len = '0;
        rise_en  = '0;
        fall_en  = '0;
        evt_clr  = '0;
        lb_en    = 1'b0;
        lb_out   = '0;
        lb_dir   = '0;
        rise_en[0] = 1'b1;

        #7;
        chk("rst_gpio", gpio_in, 32'h0);
        chk("rst_evt", evt_status, 32'h0);
        chk("rst_irq", {31'b0, irq}, 32'h0);
        #5 reset = 1'b0;
        tick(1);

        // unfiltered: 3-edge latency, event on the same edge
        pad_in[0] = 1'b1;
        tick(2);
        chk("unf_edge2", {31'b0, gpio_in[0]}, 32'h0);
        tick(1);
        chk("unf_edge3", {31'b0, gpio_in[0]}, 32'h1);
        chk("unf_evt", evt_status, 32'h1);
        chk("unf_irq", {31'b0, irq}, 32'h1);
        evt_clr[0] = 1'b1;
        tick(1);
        evt_clr[0] = 1'b0;
        chk("unf_clr", evt_status, 32'h0);

        // filter length 4 on pin 5
        filt_en[5] = 1'b1;
        filt_len   = 4'd4;
        rise_en[5] = 1'b1;
        fall_en[5] = 1'b1;
        pad_in[5]  = 1'b1;
        tick(3);
        pad_in[5]  = 1'b0;
        tick(10);
        chk("short_gpio", {31'b0, gpio_in[5]}, 32'h0);
        chk("short_evt", evt_status, 32'h0);

        pad_in[5] = 1'b1;
        tick(4);
        pad_in[5] = 1'b0;
        tick(1);
        chk("long_k4", {31'b0, gpio_in[5]}, 32'h0);
        tick(1);
        chk("long_k5", {31'b0, gpio_in[5]}, 32'h1);
        chk("long_rise_evt", evt_status, 32'h20);
        evt_clr[5] = 1'b1;
        tick(1);
        evt_clr[5] = 1'b0;
        chk("long_clr", evt_status, 32'h0);
        tick(2);
        chk("long_k8", {31'b0, gpio_in[5]}, 32'h1);
        tick(1);
        chk("long_k9", {31'b0, gpio_in[5]}, 32'h0);
        chk("long_fall_evt", evt_status, 32'h20);
        evt_clr[5] = 1'b1;
        tick(1);
        evt_clr[5] = 1'b0;

        // filt_len 0 with all filters enabled behaves as pass-through
        filt_len  = 4'd0;
        filt_en   = '1;
        pad_in[1] = 1'b1;
        tick(2);
        chk("len0_edge2", {31'b0, gpio_in[1]}, 32'h0);
        tick(1);
        chk("len0_edge3", {31'b0, gpio_in[1]}, 32'h1);

        // clear without edge, then set wins over clear
        rise_en[2] = 1'b1;
        pad_in[2]  = 1'b1;
        tick(3);
        chk("clr_evt_set", evt_status, 32'h4);
        chk("clr_irq_set", {31'b0, irq}, 32'h1);
        evt_clr[2] = 1'b1;
        tick(1);
        evt_clr[2] = 1'b0;
        chk("clr_evt_cleared", evt_status, 32'h0);
        chk("clr_irq_cleared", {31'b0, irq}, 32'h0);
        pad_in[2] = 1'b0;
        tick(4);
        pad_in[2] = 1'b1;
        tick(2);
        evt_clr[2] = 1'b1;
        tick(1);
        evt_clr[2] = 1'b0;
        chk("set_wins", evt_status, 32'h4);
        chk("set_wins_gpio", gpio_in, 32'h7);

        // asynchronous reset in the middle of a 15-cycle count on pin 3
        filt_len   = 4'd15;
        rise_en[3] = 1'b1;
        pad_in[3]  = 1'b1;
        tick(9);
        chk("mid_count_gpio", gpio_in, 32'h7);
        reset = 1'b1;
        #1;
        chk("arst_gpio", gpio_in, 32'h0);
        chk("arst_evt", evt_status, 32'h0);
        chk("arst_irq", {31'b0, irq}, 32'h0);
        #1 reset = 1'b0;
        tick(16);
        chk("rel_edge16", gpio_in, 32'h0);
        tick(1);
        chk("rel_edge17_gpio", gpio_in, 32'hF);
        chk("rel_edge17_evt", evt_status, 32'hD);
        evt_clr = '1;
        tick(1);
        evt_clr = '0;

        // loopback: pin 9 driven from lb_out when the feature is built
        filt_len   = 4'd0;
        lb_en      = 1'b1;
        lb_dir[9]  = 1'b1;
        lb_out[9]  = 1'b1;
        tick(2);
        chk("lb_edge2", {31'b0, gpio_in[9]}, 32'h0);
        tick(1);
`ifdef BIO_INFILT_LOOPBACK_EN
        chk("lb_edge3", {31'b0, gpio_in[9]}, 32'h1);
`else
        chk("lb_ignored", {31'b0, gpio_in[9]}, 32'h0);
`endif
        lb_dir[9] = 1'b0;
        tick(3);
        chk("lb_dir0_pad", {31'b0, gpio_in[9]}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
